// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for RV32 M-extension mul/mulh/mulhsu/mulhu.
// Works on operand magnitudes, one partial product per clock, then applies the sign in FIX.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_abort;
    logic                 w_last;
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_sel;

    // Operand signedness: mulh signs both, mulhsu signs only a, mul/mulhu are unsigned.
    assign w_a_signed = (i_op == 2'b01) || (i_op == 2'b10);
    assign w_b_signed = (i_op == 2'b01);
    assign w_a_neg    = w_a_signed & i_a[WIDTH-1];
    assign w_b_neg    = w_b_signed & i_b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag    = w_b_neg ? (~i_b + 1'b1) : i_b;

    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_sel  = (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_load) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (i_flush)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // flush beats everything, including a start arriving in IDLE.
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            ST_IDLE: w_load   = i_start & ~i_flush;
            ST_CALC: begin
                w_step  = ~i_flush;
                w_abort = i_flush;
            end
            ST_FIX: begin
                w_finish = ~i_flush;
                w_abort  = i_flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= 2'b00;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_op     <= i_op;
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (w_step) begin
                r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt + 1'b1;
            end else if (w_finish || w_abort) begin
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_result <= w_sel;
            end
        end
    end

    assign o_result = r_result;
    assign o_busy   = r_busy;
    assign o_stall  = r_busy;
    assign o_done   = r_done;
    assign o_state  = r_state;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, busy window, signed/unsigned halves,
// start-while-busy, flush and asynchronous reset.
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic [W-1:0] result;
    logic         busy;
    logic         stall;
    logic         done;
    logic [1:0]   state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    mul_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_flush  (flush),
        .o_result (result),
        .o_busy   (busy),
        .o_stall  (stall),
        .o_done   (done),
        .o_state  (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request; returns at #1 after the accepting edge with start dropped.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done after an accept. poke_at>0 re-asserts start (9*9) for one cycle at that count.
    task automatic wait_done(input string tag, input int poke_at);
        int lat;
        int busy_cnt;
        logic [W-1:0] exp;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (poke_at > 0 && lat == poke_at) begin
                start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (stall !== busy) check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, busy});
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd33);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check_eq({tag, "_result"}, result, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        issue(o, va, vb);
        wait_done(tag, 0);
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_flags", {29'd0, busy, stall, done}, 32'h0);
        check_eq("rst_state", {30'd0, state}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'd0, done}, 32'h0);
        run_op("mulh_m1xm1",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("mulh_minxmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mul_m1x3",     2'b00, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD);
        run_op("mulhu_max",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu_m1",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhsu_2",     2'b10, 32'h00000002, 32'h80000000, 32'h00000001);

        // Start while busy is ignored; start in the done cycle is accepted.
        exp_q.push_back(32'h0000000F);
        issue(2'b00, 32'd3, 32'd5);
        wait_done("busy_start", 10);
        exp_q.push_back(32'h00000051);
        issue(2'b00, 32'd9, 32'd9);
        wait_done("done_cycle_start", 0);

        // Flush mid-CALC: no done, result holds.
        run_op("pre_flush", 2'b00, 32'd7, 32'd6, 32'h0000002A);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", {30'd0, busy, stall}, 32'h0);
        check_eq("flush_state", {30'd0, state}, 32'h0);
        seen_done = 0;
        repeat (40) begin
            if (done) seen_done++;
            @(posedge clk);
            #1;
        end
        check_eq("flush_no_done", 32'(seen_done), 32'd0);
        check_eq("flush_result", result, 32'h0000002A);

        // flush with start in IDLE drops the request.
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check_eq("flush_start_busy", {31'd0, busy}, 32'h0);
        check_eq("flush_start_state", {30'd0, state}, 32'h0);

        // Asynchronous reset between edges, mid-CALC.
        run_op("pre_reset", 2'b00, 32'd3, 32'd5, 32'h0000000F);
        issue(2'b00, 32'd100, 32'd100);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_flags", {29'd0, busy, stall, done}, 32'h0);
        check_eq("async_rst_result", result, 32'h0);
        check_eq("async_rst_state", {30'd0, state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_reset_2x3", 2'b00, 32'd2, 32'd3, 32'h00000006);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
